// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: ALU opcodes, instruction func
// encodings, FSM states and the func-to-ALU-control decode.
package alu_pkg;

  localparam int NREGS  = 8;
  localparam int REG_W  = $clog2(NREGS);
  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_OR     = 2'b01;
  localparam logic [1:0] OP_ADDSUB = 2'b10;
  localparam logic [1:0] OP_SLT    = 2'b11;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;
  localparam logic [2:0] FN_LI  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       sub;
  } alu_ctrl_t;

  function automatic logic fn_legal(input logic [2:0] fn);
    return fn <= FN_LI;
  endfunction

  // LI has no ALU meaning; it gets the harmless AND encoding.
  function automatic alu_ctrl_t decode_func(input logic [2:0] fn);
    alu_ctrl_t ctrl;
    ctrl.op  = OP_AND;
    ctrl.sub = 1'b0;
    case (fn)
      FN_OR:   ctrl.op = OP_OR;
      FN_ADD:  ctrl.op = OP_ADDSUB;
      FN_SUB:  begin ctrl.op = OP_ADDSUB; ctrl.sub = 1'b1; end
      FN_SLT:  begin ctrl.op = OP_SLT;    ctrl.sub = 1'b1; end
      default: ctrl.op = OP_AND;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 32 register file: two async operand read ports, one debug read port,
// one synchronous write port; register 0 is hardwired to zero.
module alu_regfile #(
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] rs_addr,
  input  logic [$clog2(NREGS)-1:0] rt_addr,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [31:0]              rs_data,
  output logic [31:0]              rt_data,
  output logic [31:0]              dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [31:0]              wr_data
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the 32-bit AND/OR/ADD/SUB/SLT ALU: accepts one register-form
// instruction at a time, drives registered ALU operands, writes the result back.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int NREGS = alu_pkg::NREGS,
  parameter int IMM_W = alu_pkg::IMM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_func,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs,
  input  logic [$clog2(NREGS)-1:0] in_rt,
  input  logic [IMM_W-1:0]         in_imm,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [1:0]               alu_op,
  output logic                     alu_sub,
  input  logic [31:0]              alu_out,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [31:0]              wb_data,
  output logic                     err,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [31:0]              dbg_data
);

  localparam int IDX_W = $clog2(NREGS);

  state_t           state, next_state;
  logic [IDX_W-1:0] rd_q;
  logic [2:0]       func_q;
  logic [IMM_W-1:0] imm_q;
  logic [31:0]      result_q;
  logic [31:0]      rs_data, rt_data;
  logic             accept, legal;
  alu_ctrl_t        ctrl;

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (in_rs),
    .rt_addr  (in_rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .wr_addr  (rd_q),
    .wr_data  (result_q)
  );

  // Ready is gated by reset so the source never sees a ready while held in reset.
  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign legal    = fn_legal(in_func);
  assign ctrl     = decode_func(in_func);

  assign wb_valid = (state == WB);
  assign wb_rd    = rd_q;
  assign wb_data  = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && legal) next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // An illegal func only raises err; every other register keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      alu_sub  <= 1'b0;
      rd_q     <= '0;
      func_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        alu_a   <= rs_data;
        alu_b   <= rt_data;
        alu_op  <= ctrl.op;
        alu_sub <= ctrl.sub;
        rd_q    <= in_rd;
        func_q  <= in_func;
        imm_q   <= in_imm;
      end
      if (state == EXEC) begin
        result_q <= (func_q == FN_LI) ? {{(32-IMM_W){1'b0}}, imm_q} : alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed and random instructions are
// checked against a plain-arithmetic register-file model.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_func = '0;
  logic [2:0]  in_rd = '0, in_rs = '0, in_rt = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_op;
  logic        alu_sub;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  typedef struct {
    logic        is_err;
    logic [2:0]  rd;
    logic [31:0] data;
    logic [1:0]  op;
    logic        sub;
    int          cyc;
  } exp_t;

  exp_t        scoreboard[$];
  exp_t        mon_e;
  logic [31:0] model_rf [8];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  alu_issue_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_func  (in_func),
    .in_rd    (in_rd),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_imm   (in_imm),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_sub  (alu_sub),
    .alu_out  (alu_out),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the combinational ALU downstream of the unit.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
      default: alu_out = {31'b0, (alu_a < alu_b)};
    endcase
  end

  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return (a < b) ? 32'd1 : 32'd0;
      3'd5:    return {16'h0000, imm};
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs,
                               input logic [2:0] rt, input logic [15:0] imm);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    in_func = f; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout in_ready=%0b expected=1 at %0t", in_ready, $time);
      in_valid = 1'b0;
      return;
    end
    e.is_err = (f > 3'd5);
    e.rd     = rd;
    e.data   = refResult(f, model_rf[rs], model_rf[rt], imm);
    e.cyc    = cyc + (e.is_err ? 1 : 2);
    case (f)
      3'd1:    begin e.op = 2'b01; e.sub = 1'b0; end
      3'd2:    begin e.op = 2'b10; e.sub = 1'b0; end
      3'd3:    begin e.op = 2'b10; e.sub = 1'b1; end
      3'd4:    begin e.op = 2'b11; e.sub = 1'b1; end
      default: begin e.op = 2'b00; e.sub = 1'b0; end
    endcase
    if (!e.is_err && rd != 3'd0) model_rf[rd] = e.data;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_imm = 16'($urandom);
    in_rs = 3'($urandom);
    if (!e.is_err) begin
      @(negedge clk);
      checkOutput("ready_in_exec", {31'b0, in_ready}, 32'd0);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((scoreboard.size() != 0 || !in_ready) && n < 30);
    if (scoreboard.size() != 0 || !in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout pending=%0d in_ready=%0b expected pending=0 ready=1",
               scoreboard.size(), in_ready);
      scoreboard.delete();
    end
  endtask

  task automatic checkReg(input logic [2:0] idx, input logic [31:0] expected);
    dbg_addr = idx;
    #1;
    checkOutput($sformatf("dbg_r%0d", idx), dbg_data, expected);
  endtask

  task automatic checkAllRegs();
    for (int i = 0; i < 8; i++) checkReg(3'(i), model_rf[i]);
  endtask

  task automatic loadConst(input logic [2:0] rd, input logic [31:0] value, input logic [2:0] tmp);
    applyStimulus(3'd5, rd, 3'd0, 3'd0, value[31:16]);
    repeat (16) applyStimulus(3'd2, rd, rd, rd, 16'h0000);
    applyStimulus(3'd5, tmp, 3'd0, 3'd0, value[15:0]);
    applyStimulus(3'd1, rd, rd, tmp, 16'h0000);
  endtask

  // Monitor: every wb_valid or err pulse consumes the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || err)) begin
      if (scoreboard.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output wb_valid=%0b err=%0b expected none", wb_valid, err);
      end else begin
        mon_e = scoreboard.pop_front();
        checkOutput("err_flag", {31'b0, err}, {31'b0, mon_e.is_err});
        checkOutput("wb_valid", {31'b0, wb_valid}, {31'b0, !mon_e.is_err});
        checkOutput("latency_cycle", cyc, mon_e.cyc);
        if (mon_e.is_err) begin
          checkOutput("ready_after_err", {31'b0, in_ready}, 32'd1);
        end else begin
          checkOutput("wb_rd", {29'b0, wb_rd}, {29'b0, mon_e.rd});
          checkOutput("wb_data", wb_data, mon_e.data);
          checkOutput("alu_op", {30'b0, alu_op}, {30'b0, mon_e.op});
          checkOutput("alu_sub", {31'b0, alu_sub}, {31'b0, mon_e.sub});
          checkOutput("ready_in_wb", {31'b0, in_ready}, 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("reset_err", {31'b0, err}, 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    checkOutput("reset_alu_ctl", {29'b0, alu_op, alu_sub}, 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_release", {31'b0, in_ready}, 32'd1);

    applyStimulus(3'd5, 3'd1, 3'd0, 3'd0, 16'h0001);
    applyStimulus(3'd5, 3'd2, 3'd0, 3'd0, 16'h0003);
    waitDrain();
    checkReg(3'd1, 32'h0000_0001);
    checkReg(3'd2, 32'h0000_0003);

    applyStimulus(3'd4, 3'd3, 3'd1, 3'd2, 16'h0000);
    applyStimulus(3'd4, 3'd4, 3'd2, 3'd1, 16'h0000);
    waitDrain();
    checkReg(3'd3, 32'h0000_0001);
    checkReg(3'd4, 32'h0000_0000);

    applyStimulus(3'd5, 3'd5, 3'd0, 3'd0, 16'h8000);
    repeat (16) applyStimulus(3'd2, 3'd5, 3'd5, 3'd5, 16'h0000);
    applyStimulus(3'd2, 3'd6, 3'd5, 3'd5, 16'h0000);
    applyStimulus(3'd3, 3'd7, 3'd0, 3'd1, 16'h0000);
    waitDrain();
    checkReg(3'd5, 32'h8000_0000);
    checkReg(3'd6, 32'h0000_0000);
    checkReg(3'd7, 32'hFFFF_FFFF);

    loadConst(3'd1, 32'h341B_928C, 3'd3);
    loadConst(3'd2, 32'h1234_0149, 3'd3);
    applyStimulus(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
    waitDrain();
    checkReg(3'd3, 32'h1010_0008);
    applyStimulus(3'd1, 3'd3, 3'd1, 3'd2, 16'h0000);
    waitDrain();
    checkReg(3'd3, 32'h363F_93CD);

    applyStimulus(3'd6, 3'd4, 3'd1, 3'd2, 16'h1234);
    applyStimulus(3'd7, 3'd5, 3'd1, 3'd2, 16'h5678);
    applyStimulus(3'd2, 3'd0, 3'd2, 3'd2, 16'h0000);
    waitDrain();
    checkReg(3'd0, 32'h0000_0000);
    checkReg(3'd4, 32'h0000_0000);
    checkAllRegs();

    // Reset while ADD r1 sits in EXEC: the instruction must vanish.
    applyStimulus(3'd2, 3'd1, 3'd2, 3'd2, 16'h0000);
    #1 rst_n = 1'b0;
    scoreboard.delete();
    for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;
    #1;
    checkOutput("midreset_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("midreset_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_midreset", {31'b0, in_ready}, 32'd1);
    checkAllRegs();
    repeat (4) @(posedge clk);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                    16'($urandom));
      if (i % 10 == 9) begin
        waitDrain();
        checkAllRegs();
      end
    end

    waitDrain();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
